// File: rtl/mole_pkg.sv
// Shared types and helpers for the mole scheduler.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    UP     = 2'd2,
    RESULT = 2'd3
  } state_e;

  localparam int unsigned RND_W   = 32;
  // The hole index sits in the low bits of the random word.
  localparam int unsigned IDX_LSB = 0;
  // The gap span is taken from the top bits of the random word.
  localparam int unsigned GAP_MSB = RND_W - 1;

  // The up-time span sits directly above the hole index field.
  function automatic int unsigned up_lsb(input int unsigned idx_w);
    return IDX_LSB + idx_w;
  endfunction

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mole_scheduler_tick_timer.sv
// Loadable down-counter that decrements on tick and stops at zero.
module tick_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         tick_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, zero_d;

  // Load wins over counting; the zero flag tracks the count it accompanies.
  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (load_i) begin
      cnt_d  = value_i;
      zero_d = (value_i == '0);
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d  = cnt_q - W'(1);
      zero_d = (cnt_q == W'(1));
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: picks holes and timings from the PRNG word,
// tracks hits and misses. Optional MOLE_SPEEDUP_EN shortens the up time
// as the score climbs.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int unsigned HOLES      = 16,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned UP_MIN     = 500,
  parameter int unsigned UP_SPAN_W  = 9,
  parameter int unsigned GAP_MIN    = 200,
  parameter int unsigned GAP_SPAN_W = 8,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               start_i,
  input  logic               en_i,
  input  logic [RND_W-1:0]   random_i,
  input  logic               hit_valid_i,
  input  logic [IDX_W-1:0]   hit_idx_i,
  output logic [HOLES-1:0]   mole_onehot_o,
  output logic [IDX_W-1:0]   mole_idx_o,
  output logic               hit_pulse_o,
  output logic               miss_pulse_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0] miss_cnt_o
);

  localparam int unsigned UP_LSB  = up_lsb(IDX_W);
  localparam int unsigned UP_MAX  = UP_MIN + (1 << UP_SPAN_W) - 1;
  localparam int unsigned GAP_MAX = GAP_MIN + (1 << GAP_SPAN_W) - 1;
  localparam int unsigned T_MAX   = (UP_MAX > GAP_MAX) ? UP_MAX : GAP_MAX;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);
  localparam logic [31:0] SAT_MAX = 32'({SCORE_W{1'b1}});

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] miss_q, miss_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HOLES-1:0]   onehot_q, onehot_d;
  logic               hitp_q, hitp_d;
  logic               missp_q, missp_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;
  logic [TMR_W-1:0]   gap_val;
  logic [TMR_W-1:0]   up_base;
  logic [TMR_W-1:0]   up_val;
  logic [IDX_W:0]     idx_wrap;
  logic [IDX_W:0]     idx_bump;
  logic [IDX_W-1:0]   idx_pick;
  logic               unused_rnd;

  // Not every random bit feeds a field for every parameter set.
  assign unused_rnd = ^random_i;

  // Timer reload values taken from the random word.
  always_comb begin
    gap_val = TMR_W'(GAP_MIN) + TMR_W'(random_i[GAP_MSB -: GAP_SPAN_W]);
    up_base = TMR_W'(UP_MIN) + TMR_W'(random_i[UP_LSB +: UP_SPAN_W]);
  end

`ifdef MOLE_SPEEDUP_EN
  logic [SCORE_W-1:0] lvl_raw;
  logic [1:0]         level;

  // Every 8 hits halves the up time, capped at a quarter, never below 1.
  always_comb begin
    lvl_raw = score_q >> 3;
    level   = (lvl_raw >= SCORE_W'(2)) ? 2'd2 : lvl_raw[1:0];
    up_val  = up_base >> level;
    if (up_val == '0) begin
      up_val = TMR_W'(1);
    end
  end
`else
  // Up time is fixed by the random span alone.
  always_comb begin
    up_val = up_base;
  end
`endif

  // Fold the raw index into range, then avoid repeating the previous hole.
  always_comb begin
    idx_wrap = {1'b0, random_i[IDX_LSB +: IDX_W]};
    if (idx_wrap >= (IDX_W+1)'(HOLES)) begin
      idx_wrap = idx_wrap - (IDX_W+1)'(HOLES);
    end
    idx_bump = idx_wrap;
    if (idx_wrap[IDX_W-1:0] == idx_q) begin
      idx_bump = idx_wrap + (IDX_W+1)'(1);
      if (idx_bump == (IDX_W+1)'(HOLES)) begin
        idx_bump = '0;
      end
    end
    idx_pick = idx_bump[IDX_W-1:0];
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    miss_d   = miss_q;
    idx_d    = idx_q;
    hitp_d   = 1'b0;
    missp_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = gap_val;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            score_d  = '0;
            miss_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = gap_val;
            state_d  = GAP;
          end
        end
        GAP: begin
          if (tmr_zero) begin
            idx_d    = idx_pick;
            tmr_load = 1'b1;
            tmr_val  = up_val;
            state_d  = UP;
          end
        end
        UP: begin
          if (hit_valid_i && (hit_idx_i == idx_q)) begin
            score_d = SCORE_W'(sat_inc(32'(score_q), SAT_MAX));
            hitp_d  = 1'b1;
            state_d = RESULT;
          end else if (tmr_zero) begin
            miss_d  = SCORE_W'(sat_inc(32'(miss_q), SAT_MAX));
            missp_d = 1'b1;
            state_d = RESULT;
          end
        end
        RESULT: begin
          tmr_load = 1'b1;
          tmr_val  = gap_val;
          state_d  = GAP;
        end
        default: state_d = IDLE;
      endcase
    end
    onehot_d = (state_d == UP) ? (HOLES'(1) << idx_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      score_q  <= '0;
      miss_q   <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      hitp_q   <= 1'b0;
      missp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      miss_q   <= miss_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      hitp_q   <= hitp_d;
      missp_q  <= missp_d;
    end
  end

  tick_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .tick_i  (tick_i),
    .zero_o  (tmr_zero)
  );

  assign mole_onehot_o = onehot_q;
  assign mole_idx_o    = idx_q;
  assign hit_pulse_o   = hitp_q;
  assign miss_pulse_o  = missp_q;
  assign score_o       = score_q;
  assign miss_cnt_o    = miss_q;

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Consumes the 32-bit word from the PRNG (sampled on demand) and decides which mole pops up, for how long, and how long the gap to the next mole lasts. It also takes player hit events and produces score and miss counters. It sits between the PRNG and the display/LED driver. One mole is active at a time.

Parameters:
HOLES, 16, number of holes; must satisfy 2^(IDX_W-1) < HOLES <= 2^IDX_W
IDX_W, 4, hole index width
UP_MIN, 500, minimum mole-up time in ticks
UP_SPAN_W, 9, random span bits added to the up time (0..2^UP_SPAN_W-1)
GAP_MIN, 200, minimum gap time in ticks
GAP_SPAN_W, 8, random span bits added to the gap time
SCORE_W, 8, width of the score and miss counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  1 ms strobe, one clk wide; all timers count only on tick
start  in  1  pulse; clears counters and leaves IDLE
en  in  1  game running; 0 forces IDLE
random  in  32  PRNG output, sampled only at the instants defined below
hit_valid  in  1  one-cycle player hit strobe
hit_idx  in  IDX_W  hole struck
mole_onehot  out  HOLES  lit hole; all zero when no mole is up
mole_idx  out  IDX_W  index of the current or last mole
hit_pulse  out  1  one cycle on a successful hit
miss_pulse  out  1  one cycle on a timeout
score  out  SCORE_W  saturating hit count
miss_cnt  out  SCORE_W  saturating miss count

Behaviour:
- Reset values: all outputs 0; state IDLE; prev_idx = 0.
- States: IDLE, GAP, UP, RESULT.
- IDLE:
  - On start & en: clear score and miss_cnt.
  - Load gap timer = GAP_MIN + random[31 -: GAP_SPAN_W].
  - Go to GAP.
- GAP:
  - Timer decrements on tick; it reaches 0 on the tick that counts the last unit.
  - When the timer is 0, on the next clk: sample random.
  - idx = random[IDX_W-1:0]; if idx >= HOLES, idx -= HOLES.
  - If idx == prev_idx, idx = (idx+1) wrapping to 0 at HOLES.
  - Up timer = UP_MIN + random[IDX_W +: UP_SPAN_W].
  - Latch mole_idx = prev_idx = idx. Go to UP.
  - mole_onehot is asserted from the first cycle in UP.
- UP:
  - hit_valid with hit_idx == mole_idx: score += 1 (saturates at all-ones); go to RESULT with hit.
  - hit_valid with any other index is ignored.
  - Up timer reaching 0 (same decrement rule as GAP): miss_cnt += 1 (saturating); go to RESULT with miss.
  - Hit and expiry in the same cycle: the hit wins; miss_cnt is unchanged.
- RESULT:
  - Exactly one cycle; mole_onehot = 0.
  - Asserts hit_pulse or miss_pulse, never both.
  - Loads a new gap timer from random (same rule as IDLE); next state GAP.
- Latency: a hit strobe produces hit_pulse and a score update on the next clk, and mole_onehot drops on that same edge.
- en low in any state:
  - Next state is IDLE; mole_onehot = 0 on the next edge.
  - score and miss_cnt hold; no pulses.
  - Returning from IDLE requires start.
- start while not in IDLE is ignored.
- tick and the timer both being 0 is legal; the zero check uses the timer value, not tick.
- Asynchronous reset mid-game returns immediately to the reset values above.

Optional Feature:
MOLE_SPEEDUP_EN
- Defined: level = min(score >> 3, 2). The loaded up time is (UP_MIN + span) >> level, floored at 1. Each 8 hits shortens the mole window, up to 4x.
- Undefined: level logic is absent and the up time is fixed as above.

Decomposition:
- Package mole_pkg holds:
  - state enum {IDLE, GAP, UP, RESULT}
  - random-field slice constants (IDX_LSB, UP_LSB, GAP_MSB)
  - a saturating-increment function
- Sub-module tick_timer: loadable down-counter with load, value, tick inputs and a zero flag. Instantiated once, shared between GAP and UP because the two phases never overlap.

Test Plan:
All scenarios use HOLES=16, UP_MIN=4, UP_SPAN_W=2, GAP_MIN=2, GAP_SPAN_W=2, tick tied 1.
- Reset then start with random=0: GAP lasts 2 ticks. The first mole has idx 0 equal to prev_idx 0, so it is bumped to idx 1 (mole_onehot=16'h0002). Up time is 4.
- No hit: miss_pulse fires 4 ticks after UP entry, miss_cnt=1, score=0, mole_onehot returns to 0.
- random=32'h0000_0007 in UP, hit_idx=7 on the 2nd UP cycle: hit_pulse on the next edge, score=1, and RESULT lasts exactly 1 cycle.
- Wrong hit_idx=3 while mole 7 is up: ignored. A hit arriving on the same cycle the timer expires gives score+1 with miss_cnt unchanged.
- Force score to 8'hFF and hit again: score stays FF. Drop en mid-UP: next edge shows IDLE and mole_onehot=0, counters held, and there is no activity until start.
- With MOLE_SPEEDUP_EN, score=16 and a random span of 0: up time is 4>>2=1 tick.
